// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial link blocks (PISO, SIPO, deserializer control).
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH      = 4;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel word handshake in, qualified serial stream out.
interface piso_serializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sdo;
  logic             sdo_valid;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, sdo, sdo_valid, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sdo, sdo_valid, done
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Bits-remaining counter: loads WIDTH-1, counts down to 0 and holds there.
module piso_bit_counter #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WIDTH - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter feeding the downstream SIPO, with gapless word chaining.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg_p1;
  logic             sdo_p1;
  logic             vld_p1;
  logic             done_p1;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             ready;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The bit that becomes current once w has been advanced by one position.
  function automatic logic next_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-2] : w[1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .dec   ((state == SHIFT) && !last),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == IDLE) || ((state == SHIFT) && (cnt == '0));
    accept = bus.din_valid && ready;
  end

  // p0 -> p1: capture on accept, otherwise advance one bit per cycle while shifting
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_p1 <= '0;
      sdo_p1   <= IDLE_LEVEL;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      done_p1 <= (state == SHIFT) && last;
      if (accept) begin
        shreg_p1 <= bus.din;
        sdo_p1   <= first_bit(bus.din);
        vld_p1   <= 1'b1;
      end else if ((state == SHIFT) && !last) begin
        shreg_p1 <= advance(shreg_p1);
        sdo_p1   <= next_bit(shreg_p1);
        vld_p1   <= 1'b1;
      end else if (state == SHIFT) begin
        sdo_p1 <= IDLE_LEVEL;
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.din_ready = ready;
  assign bus.sdo       = sdo_p1;
  assign bus.sdo_valid = vld_p1;
  assign bus.done      = done_p1;

endmodule
